// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   DEF_WIDTH : default operand/result width
//   state_t   : sequencer states (IDLE, RUN, DONE)
package sub_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fs_bit.sv
// One-bit full subtractor: diff = x - y - bin, with borrow out.
// Ports:
//   x    : minuend bit
//   y    : subtrahend bit
//   bin  : borrow in
//   diff : difference bit
//   bout : borrow out (set when x < y + bin)
module fs_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = x ^ y ^ bin;
    assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtraction sequencer: d = a - b - borrow_in (mod 2^WIDTH),
// processed LSB first through one shared full-subtractor cell.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   start            : request; accepted only while ready=1
//   a, b, borrow_in  : operands, sampled on the accepting edge
//   ready            : high in IDLE
//   busy             : high while bits are being processed
//   done             : one-cycle pulse when d/borrow have just updated
//   d, borrow        : registered result and final borrow, held until next result
module serial_subtractor_ctrl
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             borrow
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t             r_state;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-1:0]   r_acc;
    logic               r_bq;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_d;
    logic               r_borrow;

    logic               w_diff;
    logic               w_bout;
    logic               w_last;
    logic [WIDTH-1:0]   w_acc_next;

    // Shared subtract cell always works on the current LSBs and running borrow.
    fs_bit u_fs_bit (
        .x    (r_sa[0]),
        .y    (r_sb[0]),
        .bin  (r_bq),
        .diff (w_diff),
        .bout (w_bout)
    );

    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    // New bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
    assign w_acc_next = {w_diff, r_acc[WIDTH-1:1]};

    // Sequencer, datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_acc    <= '0;
            r_bq     <= 1'b0;
            r_cnt    <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_d      <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_bq    <= borrow_in;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_next;
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_bq  <= w_bout;
                    if (w_last) begin
                        r_d      <= w_acc_next;
                        r_borrow <= w_bout;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready  = r_ready;
    assign busy   = r_busy;
    assign done   = r_done;
    assign d      = r_d;
    assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl (WIDTH=8).
module tb_serial_subtractor_ctrl;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] d;
        logic         b;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         borrow;

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    bit   rst_flag = 1'b0;
    bit   prev_done = 1'b0;
    logic [W-1:0] hold_d = '0;
    logic         hold_b = 1'b0;
    exp_t q[$];
    int   done_cycs[$];

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .borrow_in (borrow_in),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .d         (d),
        .borrow    (borrow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer subtraction; negative result means borrow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic bi, input int c);
        exp_t e;
        int   r;
        r     = int'(x) - int'(y) - int'(bi);
        e.d   = W'(r);
        e.b   = (r < 0);
        e.cyc = c;
        return e;
    endfunction

    // Acceptance tracker: push expectation on every accepting edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            rst_flag = 1'b1;
            q.delete();
        end else if (start && ready) begin
            q.push_back(model(a, b, borrow_in, cyc));
        end
    end

    // Monitor: compare results on done, check hold behaviour otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (rst_flag) begin
            hold_d   = '0;
            hold_b   = 1'b0;
            rst_flag = 1'b0;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cycs.push_back(cyc);
            chk("done_single_pulse", 32'(prev_done), 32'd0);
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("result_d", 32'(d), 32'(e.d));
                chk("result_borrow", 32'(borrow), 32'(e.b));
                chk("latency", 32'(cyc - e.cyc), 32'(W));
                chk("done_ready_low", 32'(ready), 32'd0);
                chk("done_busy_low", 32'(busy), 32'd0);
                hold_d = e.d;
                hold_b = e.b;
            end
        end else begin
            chk("hold_d", 32'(d), 32'(hold_d));
            chk("hold_borrow", 32'(borrow), 32'(hold_b));
        end
        if (prev_done) chk("ready_after_done", 32'(ready), 32'd1);
        prev_done = (done === 1'b1);
    end

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) chk("wait_ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || ready !== 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    // Issue one operation; start is optionally left high afterwards.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic bi, input bit keep);
        wait_ready();
        a         = x;
        b         = y;
        borrow_in = bi;
        start     = 1'b1;
        @(negedge clk);
        if (!keep) start = 1'b0;
        a         = W'($urandom);
        b         = W'($urandom);
        borrow_in = 1'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int n;
        rst_n     = 1'b0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(8'h5A, 8'h23, 1'b0, 1'b0); drain();
        chk("dir_5A_23", 32'(d), 32'h37);
        issue(8'h23, 8'h5A, 1'b0, 1'b0); drain();
        chk("dir_23_5A", 32'({borrow, d}), 32'h1C9);
        issue(8'h00, 8'h00, 1'b1, 1'b0); drain();
        chk("dir_00_00_b1", 32'({borrow, d}), 32'h1FF);
        issue(8'hFF, 8'h00, 1'b1, 1'b0); drain();
        chk("dir_FF_00_b1", 32'({borrow, d}), 32'h0FE);

        // Start during RUN is ignored
        c0 = done_cnt;
        issue(8'h10, 8'h01, 1'b0, 1'b0);
        @(negedge clk); @(negedge clk);
        chk("run_busy", 32'(busy), 32'd1);
        a = 8'h00; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (12) @(negedge clk);
        chk("ignored_start_one_done", 32'(done_cnt - c0), 32'd1);
        chk("ignored_start_result", 32'({borrow, d}), 32'h00F);

        // Reset mid-RUN aborts the operation
        c0 = done_cnt;
        issue(8'h80, 8'h01, 1'b0, 1'b0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_d", 32'(d), 32'd0);
        chk("abort_borrow", 32'(borrow), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (15) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - c0), 32'd0);

        // Start held high: back-to-back ops every WIDTH+2 cycles
        done_cycs.delete();
        wait_ready();
        a = 8'h05; b = 8'h03; borrow_in = 1'b0; start = 1'b1;
        repeat (45) @(negedge clk);
        start = 1'b0;
        drain();
        chk("held_done_count_ge4", 32'(done_cycs.size() >= 4), 32'd1);
        chk("held_last_d", 32'(d), 32'h02);
        for (int i = 1; i < done_cycs.size(); i++)
            chk("held_interval", 32'(done_cycs[i] - done_cycs[i-1]), 32'(W + 2));

        // Random operations with random gaps and occasional held start
        for (int i = 0; i < 1000; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
            n = $urandom_range(0, 3);
            repeat (n) @(negedge clk);
        end
        start = 1'b0;
        drain();
        repeat (12) @(negedge clk);
        drain();
        chk("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
Bit-serial subtraction sequencer. It computes D = A - B - BIN by reusing a single full-subtractor cell over WIDTH cycles, LSB first, with a registered borrow between bits. A start/ready/done handshake wraps the operation, so a host FSM or bus slave can time-share one small subtract cell instead of a WIDTH-wide ripple array. Results and final borrow are registered and held until the next accepted start.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNT_W, $clog2(WIDTH), bit-counter width (derived; do not override)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising clk
start  in  1  request a subtraction; accepted only when ready=1
a  in  WIDTH  minuend, sampled on the accepting edge
b  in  WIDTH  subtrahend, sampled on the accepting edge
borrow_in  in  1  initial borrow, sampled on the accepting edge (for chaining)
ready  out  1  high in IDLE; start is accepted only in this state
busy  out  1  high while bits are being processed (RUN)
done  out  1  one-cycle pulse: d/borrow just updated
d  out  WIDTH  difference, registered, held until next accept
borrow  out  1  final borrow out (1 = a < b + borrow_in, unsigned), held

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, ready=1, busy=0, done=0, d=0, borrow=0, counter=0, shift registers=0. Reset applies in any state and aborts an in-flight operation; the partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE: if start=1 at an edge (E0), load sa<=a, sb<=b, bq<=borrow_in, cnt<=0, go to RUN. ready=1 only in IDLE.
- RUN (busy=1): on each edge E1..EWIDTH, the cell computes diff = sa[0]^sb[0]^bq and bout = (~sa[0]&sb[0]) | (~sa[0]&bq) | (sb[0]&bq). The block shifts diff into an accumulator MSB-first so bit 0 ends at LSB, shifts sa/sb right by 1, sets bq<=bout, cnt<=cnt+1.
- On edge EWIDTH (cnt==WIDTH-1): d<=accumulated result, borrow<=bout, go to DONE.
- DONE: done=1 for exactly this cycle; ready=0, busy=0. Next edge goes unconditionally to IDLE.
- Latency: done is high in the cycle following edge E0+WIDTH. Issue interval is WIDTH+2 cycles minimum.
- start while busy or in DONE is ignored and not queued. If start is held high continuously, the next operation is accepted on the first edge in IDLE.
- a, b and borrow_in may change freely after the accepting edge.
- d/borrow change only on the DONE-entry edge or on reset. They are stable otherwise, including during the next RUN.
- Arithmetic is unsigned modulo 2^WIDTH; the borrow chain is exact. There is no overflow flag (signed overflow is out of scope).
- Counter does not wrap: RUN always exits at cnt==WIDTH-1.

Decomposition:
- Shared package sub_pkg: state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
- One sub-module: fs_bit (pure combinational 1-bit full subtractor: x, y, bin -> diff, bout) with the exact equations above. It is instantiated once. fs_bit is a new cell with a verified borrow equation; the existing full-subtractor cell is not reused here.
- The FSM, counter and shift registers live in serial_subtractor_ctrl.

Test Plan:
- Reset, then a=8'h5A, b=8'h23, borrow_in=0, start pulse -> done 8 cycles after accept; d=8'h37, borrow=0; ready returns next cycle.
- a=8'h23, b=8'h5A, borrow_in=0 -> d=8'hC9, borrow=1.
- a=8'h00, b=8'h00, borrow_in=1 -> d=8'hFF, borrow=1. Also a=8'hFF, b=8'h00, borrow_in=1 -> d=8'hFE, borrow=0.
- Accept a=8'h10, b=8'h01. Pulse start with a=8'h00, b=8'hFF at cycle 3 of RUN -> ignored; result d=8'h0F, borrow=0; exactly one done pulse.
- Accept a=8'h80, b=8'h01. Assert rst_n=0 for one edge after 3 RUN edges -> next cycle d=0, borrow=0, done=0, ready=1, busy=0; no done pulse follows.
- Hold start=1 with a=8'h05, b=8'h03 continuously -> results d=8'h02 every WIDTH+2=10 cycles; d holds between done pulses. Scoreboard against (a-b-borrow_in) mod 256 over 1000 random operands.
